pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Drives the enable and clear inputs of the IF/ID and ID/EX pipeline registers, and the PC enable.
- Holds the HI/LO multiply/divide busy counter, the one-shot interrupt-flush sequencer and the stalled-branch flag.
- Lives in the datapath top beside the decoder hazard compare logic and CP0.
- Every enable, clear and flag that a pipeline register consumes originates here.

Parameters:
MULT_CYCLES, 5, cycles HI/LO stay busy after a mult/multu issues in EX
DIV_CYCLES, 10, cycles HI/LO stay busy after a div/divu issues in EX
CNT_W, 4, busy counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-low (0 = reset)
stall_data  in  1  combinational load-use / Tuse>Tnew stall request from the decoder compare
md_start_e  in  1  mult/div instruction valid in EX this cycle
md_is_div_e  in  1  with md_start_e: 1 = div/divu, 0 = mult/multu
md_use_d  in  1  instruction in ID is mult/div/mfhi/mflo/mthi/mtlo
jump_d  in  1  instruction in ID is a branch or jump
int_req  in  1  level exception/interrupt request from CP0 (M stage)
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX register enable
id_ex_clr  out  1  ID/EX bubble insert
int_clr  out  1  flush all pipeline registers
md_busy  out  1  HI/LO unit busy
md_done  out  1  single-cycle pulse on the last busy cycle
stall_jump_d  out  1  feeds the ID/EX stalled-branch flag input

Behaviour:
- Reset (reset==0 at posedge):
  - Counter = 0, FSM = RUN, stalled_q = 0, int_armed = 1.
  - While reset is low: pc_en = if_id_en = id_ex_en = 1; id_ex_clr, int_clr, md_busy, md_done, stall_jump_d = 0.
  - The ID/EX register's own reset clears its contents.
  - Reset mid-divide aborts the count immediately.
- Busy counter:
  - If cnt==0 and md_start_e: load MULT_CYCLES or DIV_CYCLES according to md_is_div_e.
  - Else if cnt!=0: decrement.
  - md_start_e while cnt!=0 is ignored. It cannot occur legally because of the md stall.
  - md_busy = (cnt!=0). md_done = (cnt==1).
- Stall: stall = stall_data | (md_use_d & (md_busy | md_start_e)).
  - md_start_e is included so a dependent instruction issued in the cycle directly behind the mult is caught.
  - When FSM == RUN and stall: pc_en = 0, if_id_en = 0, id_ex_clr = 1, id_ex_en = 1.
  - Otherwise in RUN: all enables = 1, id_ex_clr = 0.
  - Stall is held as long as the condition holds. The bubble count equals the number of stall cycles.
- FSM states:
  - RUN -> FLUSH when int_req & int_armed.
  - FLUSH -> RUN unconditionally, after exactly 1 cycle.
  - int_clr = 1 only during the FLUSH cycle. pc_en = 1 in FLUSH (the handler vector loads). The stall is overridden.
  - int_armed clears on entry to FLUSH and sets when int_req is sampled 0.
  - A level int_req held for N cycles therefore produces exactly one flush.
- Interrupt during busy: the counter keeps running because the HI/LO result commits architecturally, and the flush does not touch cnt.
- stalled_q captures (RUN & stall) every cycle. stall_jump_d = jump_d & stalled_q & ~stall, i.e. the branch that is finally released after a stall.
- Simultaneous int_req and stall_data: FLUSH wins. stalled_q is written 0.

Decomposition:
- Shared package: FSM state encoding (RUN=1'b0, FLUSH=1'b1) and the MULT_CYCLES/DIV_CYCLES defaults, also used by the HI/LO datapath.
- One sub-module, md_busy_counter: load/decrement counter plus the busy/done outputs.
- The rest stays flat.

Test Plan:
- Reset held low for 3 cycles, then released → pc_en = if_id_en = id_ex_en = 1, all other outputs 0, md_busy = 0.
- stall_data = 1 for 2 cycles → pc_en = 0 and id_ex_clr = 1 for exactly 2 cycles, then enables return to 1.
- md_start_e = 1, md_is_div_e = 1, then md_use_d = 1 from the next cycle → md_busy high for 10 cycles, md_done on the 10th, stall for 10 cycles, released on the cycle after done. Repeat with mult → 5 cycles.
- int_req held high for 4 cycles during RUN → int_clr high for exactly 1 cycle (the cycle after first sampling), no second flush until int_req drops and rises again.
- int_req and stall_data both asserted during a divide → int_clr = 1 with pc_en = 1, counter continues decrementing, md_done still pulses at cycle 10.
- jump_d = 1 with stall_data = 1 for 1 cycle then 0 → stall_jump_d = 1 for exactly the release cycle. jump_d with no stall → stall_jump_d stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the HI/LO datapath:
// controller state encoding and the multiply/divide latency defaults.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W_DEF       = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard request inputs and pipeline-register control outputs between the
// datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;

  logic stall_data;
  logic md_start_e;
  logic md_is_div_e;
  logic md_use_d;
  logic jump_d;
  logic int_req;

  logic pc_en;
  logic if_id_en;
  logic id_ex_en;
  logic id_ex_clr;
  logic int_clr;
  logic md_busy;
  logic md_done;
  logic stall_jump_d;

  modport master (
    output stall_data, md_start_e, md_is_div_e, md_use_d, jump_d, int_req,
    input  pc_en, if_id_en, id_ex_en, id_ex_clr, int_clr, md_busy, md_done, stall_jump_d
  );

  modport slave (
    input  stall_data, md_start_e, md_is_div_e, md_use_d, jump_d, int_req,
    output pc_en, if_id_en, id_ex_en, id_ex_clr, int_clr, md_busy, md_done, stall_jump_d
  );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// HI/LO busy counter: loads the mult/div latency when idle and an op issues in EX,
// then counts down; done marks the last busy cycle.
module md_busy_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  // NOTE: registered state always uses non-blocking assignment so every flop
  // samples the values present before the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      // A start while counting cannot occur legally, so it is only honoured when idle.
      if (start) cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: PC / IF/ID / ID/EX enables and clears, one-shot
// interrupt flush, HI/LO busy tracking and the released-branch flag.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  hz_state_t state, state_nxt;
  logic      int_armed;
  logic      stalled_q;
  logic      stall;
  logic      flush_go;
  logic      cnt_busy;
  logic      cnt_done;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_cnt (
    .clk    (clk),
    .reset  (reset),
    .start  (hz.md_start_e),
    .is_div (hz.md_is_div_e),
    .busy   (cnt_busy),
    .done   (cnt_done)
  );

  // md_start_e catches an HI/LO consumer sitting directly behind the mult/div.
  assign stall    = hz.stall_data | (hz.md_use_d & (cnt_busy | hz.md_start_e));
  assign flush_go = (state == RUN) & hz.int_req & int_armed;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nxt       = state;
    hz.pc_en        = 1'b1;
    hz.if_id_en     = 1'b1;
    hz.id_ex_en     = 1'b1;
    hz.id_ex_clr    = 1'b0;
    hz.int_clr      = 1'b0;
    hz.md_busy      = cnt_busy;
    hz.md_done      = cnt_done;
    hz.stall_jump_d = hz.jump_d & stalled_q & ~stall;

    if (!reset) begin
      state_nxt       = RUN;
      hz.md_busy      = 1'b0;
      hz.md_done      = 1'b0;
      hz.stall_jump_d = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (flush_go) state_nxt = FLUSH;
          if (stall) begin
            hz.pc_en     = 1'b0;
            hz.if_id_en  = 1'b0;
            hz.id_ex_clr = 1'b1;
          end
        end
        FLUSH: begin
          // Handler vector loads this cycle; any pending stall is overridden.
          state_nxt  = RUN;
          hz.int_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      int_armed <= 1'b1;
      stalled_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // Re-arm only after the level request has been seen low, giving one flush per assertion.
      if (flush_go)         int_armed <= 1'b0;
      else if (!hz.int_req) int_armed <= 1'b1;
      stalled_q <= (state == RUN) & stall & ~flush_go;
    end
  end

endmodule
